// File: rtl/sfr_bus_master_v1_if.sv
// ---------------------------------------------------------------------------
// sfr_bus_master_v1_if
//
// Bundles the core-side request/response handshake and the SFR bus between
// the initiator (sfr_bus_master_v1) and its environment.
//
// Signals:
//   cpu_req_valid / cpu_req_ready   request handshake
//   cpu_req_we                      1 = store, 0 = load
//   cpu_req_addr                    byte address, bits [1:0] ignored
//   cpu_req_wdata / cpu_req_be      store data and byte enables
//   cpu_rsp_valid                   one-cycle response pulse
//   cpu_rsp_rdata / cpu_rsp_err     load data, address error
//   sys_addr / sys_wr_en            SFR address (word aligned), write strobe
//   sys_sw_value                    SFR write data
//   sfr_rd_dout                     wired-OR SFR read data
//
// Modports:
//   master : the bus initiator (drives requests onto the SFR bus)
//   slave  : the environment (core plus SFR peripherals)
// ---------------------------------------------------------------------------
interface sfr_bus_master_v1_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                      cpu_req_valid;
  logic                      cpu_req_ready;
  logic                      cpu_req_we;
  logic [ADDR_WIDTH-1:0]     cpu_req_addr;
  logic [DATA_WIDTH-1:0]     cpu_req_wdata;
  logic [DATA_WIDTH/8-1:0]   cpu_req_be;
  logic                      cpu_rsp_valid;
  logic [DATA_WIDTH-1:0]     cpu_rsp_rdata;
  logic                      cpu_rsp_err;
  logic [ADDR_WIDTH-1:0]     sys_addr;
  logic                      sys_wr_en;
  logic [DATA_WIDTH-1:0]     sys_sw_value;
  logic [DATA_WIDTH-1:0]     sfr_rd_dout;

  modport master (
    input  cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata, cpu_req_be,
    input  sfr_rd_dout,
    output cpu_req_ready, cpu_rsp_valid, cpu_rsp_rdata, cpu_rsp_err,
    output sys_addr, sys_wr_en, sys_sw_value
  );

  modport slave (
    output cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata, cpu_req_be,
    output sfr_rd_dout,
    input  cpu_req_ready, cpu_rsp_valid, cpu_rsp_rdata, cpu_rsp_err,
    input  sys_addr, sys_wr_en, sys_sw_value
  );
endinterface

// File: rtl/sfr_bus_master_v1.sv
// ---------------------------------------------------------------------------
// sfr_bus_master_v1
//
// Initiator side of the peripheral SFR bus. Accepts one word-addressed
// load/store from the core at a time, drives sys_addr / sys_wr_en /
// sys_sw_value to the SFR peripherals, samples the wired-OR read bus and
// returns a single-cycle response. Partial-byte stores are done as
// read-modify-write because SFRs only take full-word writes.
//
// Ports:
//   sys_clk     system clock
//   sys_rst_n   synchronous reset, active-low (honoured regardless of enable)
//   sys_clk_en  global clock enable; all state holds while 0
//   bus         sfr_bus_master_v1_if.master (request/response + SFR bus)
//
// Parameters:
//   DATA_WIDTH  SFR data width, multiple of 8
//   ADDR_WIDTH  SFR address width
//   RD_LATENCY  extra cycles sys_addr is held before sampling (0..7)
//   SFR_BASE    lowest legal SFR byte address (address check only)
//   SFR_SIZE    legal window size in bytes (address check only)
//
// Optional feature macro: SFR_BUS_ADDR_CHECK_EN
//   Defined   : out-of-window requests respond with cpu_rsp_err=1 and
//               never reach the bus.
//   Undefined : cpu_rsp_err is always 0, every address goes to the bus.
// ---------------------------------------------------------------------------
module sfr_bus_master_v1 #(
  parameter int                     DATA_WIDTH = 32,
  parameter int                     ADDR_WIDTH = 32,
  parameter int                     RD_LATENCY = 0,
  parameter logic [ADDR_WIDTH-1:0]  SFR_BASE   = '0,
  parameter longint unsigned        SFR_SIZE   = 4096
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 sys_clk_en,
  sfr_bus_master_v1_if.master  bus
);

  localparam int BE_W = DATA_WIDTH / 8;
  // Counter is 3 bits wide; RD_LATENCY above 7 is not supported.
  localparam logic [2:0] LAT = 3'(RD_LATENCY);

`ifdef SFR_BUS_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif

  // One extra bit so SFR_BASE+SFR_SIZE cannot wrap at the top of the map.
  localparam logic [ADDR_WIDTH:0] WIN_LO = {1'b0, SFR_BASE};
  localparam logic [ADDR_WIDTH:0] WIN_HI = WIN_LO + SFR_SIZE[ADDR_WIDTH:0];

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    RMW_RD = 3'd2,
    WR     = 3'd3,
    RESP   = 3'd4
  } state_t;

  function automatic logic [DATA_WIDTH-1:0] byte_mask(input logic [BE_W-1:0] be);
    logic [DATA_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < BE_W; i++) begin
      m[i*8 +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] rmw_merge(
    input logic [DATA_WIDTH-1:0] rd_val,
    input logic [DATA_WIDTH-1:0] wr_val,
    input logic [BE_W-1:0]       be
  );
    logic [DATA_WIDTH-1:0] m;
    m = byte_mask(be);
    return (rd_val & ~m) | (wr_val & m);
  endfunction

  state_t                 state, state_nx;
  logic [2:0]             cnt, cnt_nx;
  logic [ADDR_WIDTH-1:0]  sys_addr_q;
  logic                   err_q;
  logic                   we_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic [BE_W-1:0]        be_q;
  logic [DATA_WIDTH-1:0]  rd_data_q;

  logic                   in_window;
  logic                   req_err;
  logic                   accept;
  logic                   sample;

  logic                   req_ready;
  logic                   wr_en;
  logic [DATA_WIDTH-1:0]  sw_value;
  logic                   rsp_valid;
  logic [DATA_WIDTH-1:0]  rsp_rdata;
  logic                   rsp_err;

  assign in_window = ({1'b0, bus.cpu_req_addr} >= WIN_LO) &&
                     ({1'b0, bus.cpu_req_addr} <  WIN_HI);
  assign req_err   = ADDR_CHECK && !in_window;

  assign accept = (state == IDLE) && bus.cpu_req_valid;
  // Capture happens in the last read cycle of both RD and RMW_RD.
  assign sample = ((state == RD) || (state == RMW_RD)) && (cnt == LAT);

  // Next-state and output decode
  always_comb begin
    state_nx  = state;
    cnt_nx    = '0;
    req_ready = 1'b0;
    wr_en     = 1'b0;
    sw_value  = '0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (bus.cpu_req_valid) begin
          if (req_err)                      state_nx = RESP;
          else if (!bus.cpu_req_we)         state_nx = RD;
          else if (&bus.cpu_req_be)         state_nx = WR;
          else if (bus.cpu_req_be == '0)    state_nx = RESP;
          else                              state_nx = RMW_RD;
        end
      end
      RD, RMW_RD: begin
        if (cnt == LAT) state_nx = (state == RD) ? RESP : WR;
        else            cnt_nx   = cnt + 3'd1;
      end
      WR: begin
        wr_en    = 1'b1;
        sw_value = wdata_q;
        state_nx = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = (we_q || err_q) ? '0 : rd_data_q;
        rsp_err   = err_q;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Control state
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      sys_addr_q <= '0;
      err_q      <= 1'b0;
      we_q       <= 1'b0;
    end else if (sys_clk_en) begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        err_q <= req_err;
        we_q  <= bus.cpu_req_we;
        // Rejected addresses never reach the bus, so sys_addr keeps its value.
        if (!req_err) sys_addr_q <= {bus.cpu_req_addr[ADDR_WIDTH-1:2], 2'b00};
      end
    end
  end

  // Datapath registers; only meaningful while the FSM says so
  always_ff @(posedge sys_clk) begin
    if (sys_clk_en) begin
      if (accept) begin
        wdata_q <= bus.cpu_req_wdata;
        be_q    <= bus.cpu_req_be;
      end
      if (sample) begin
        rd_data_q <= bus.sfr_rd_dout;
        if (state == RMW_RD) wdata_q <= rmw_merge(bus.sfr_rd_dout, wdata_q, be_q);
      end
    end
  end

  assign bus.cpu_req_ready = req_ready;
  assign bus.cpu_rsp_valid = rsp_valid;
  assign bus.cpu_rsp_rdata = rsp_rdata;
  assign bus.cpu_rsp_err   = rsp_err;
  assign bus.sys_addr      = sys_addr_q;
  assign bus.sys_wr_en     = wr_en;
  assign bus.sys_sw_value  = sw_value;

endmodule

// File: tb/tb_sfr_bus_master_v1.sv
// ---------------------------------------------------------------------------
// tb_sfr_bus_master_v1
//
// Drives word-addressed load/store transactions into sfr_bus_master_v1 and
// acts as the SFR peripheral block (a small register array). Expected
// responses, latencies and bus writes come from a transaction-level model
// of the bus protocol. Read data is only valid on the single cycle the
// design is supposed to sample it; every other cycle carries junk.
// ---------------------------------------------------------------------------
module tb_sfr_bus_master_v1;

  localparam int L = 2;
  localparam logic [31:0] BASE = 32'h100;
  localparam logic [31:0] SIZE = 32'h40;
`ifdef SFR_BUS_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  logic sys_clk_en;

  sfr_bus_master_v1_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  sfr_bus_master_v1 #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .RD_LATENCY (L),
    .SFR_BASE   (BASE),
    .SFR_SIZE   (64'(SIZE))
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .sys_clk_en (sys_clk_en),
    .bus        (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] mem [0:127];
  logic [31:0] last_addr;
  logic [31:0] last_wr;
  logic [31:0] last_rdata;
  logic        last_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = w[b*8 +: 8];
    return r;
  endfunction

  function automatic bit out_of_win(input logic [31:0] a);
    return ADDR_CHECK && ((a < BASE) || (a >= BASE + SIZE));
  endfunction

  task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input bit stall_wr);
    bit          err, bus_rd, do_wr, seen, stalled;
    int          exp_lat, k, nwr, stall_left, idx;
    logic [31:0] old, exp_wval, exp_rdata, aligned, wval;
    aligned   = {addr[31:2], 2'b00};
    idx       = int'(addr[8:2]);
    err       = out_of_win(addr);
    old       = mem[idx];
    bus_rd    = !err && (!we || (be != 4'hF && be != 4'h0));
    do_wr     = !err && we && (be != 4'h0);
    exp_wval  = merge(old, wdata, be);
    exp_rdata = (!err && !we) ? old : 32'h0;
    if (err)              exp_lat = 1;
    else if (!we)         exp_lat = L + 2;
    else if (be == 4'hF)  exp_lat = 2;
    else if (be == 4'h0)  exp_lat = 1;
    else                  exp_lat = L + 3;
    if (do_wr && stall_wr) exp_lat += 3;

    @(negedge sys_clk);
    chk("idle_ready", 32'(bus.cpu_req_ready), 32'd1);
    chk("idle_rsp",   32'(bus.cpu_rsp_valid), 32'd0);
    chk("idle_wr_en", 32'(bus.sys_wr_en),     32'd0);
    chk("idle_addr",  bus.sys_addr,           last_addr);
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_we    = we;
    bus.cpu_req_addr  = addr;
    bus.cpu_req_wdata = wdata;
    bus.cpu_req_be    = be;
    bus.sfr_rd_dout   = $urandom;

    k = 0; nwr = 0; seen = 0; stalled = 0; stall_left = 0; wval = 32'h0;
    while (!seen && k < 40) begin
      @(negedge sys_clk);
      k++;
      bus.cpu_req_valid = 1'b0;
      bus.cpu_req_wdata = $urandom;
      bus.cpu_req_be    = 4'($urandom);
      sys_clk_en = 1'b1;
      if (stall_left > 0) begin
        sys_clk_en = 1'b0;
        stall_left--;
      end else if (stall_wr && !stalled && bus.sys_wr_en) begin
        sys_clk_en = 1'b0;
        stall_left = 2;
        stalled    = 1'b1;
      end
      bus.sfr_rd_dout = (bus_rd && k == L + 1) ? old : $urandom;
      if (bus.sys_wr_en) begin
        chk("wr_addr", bus.sys_addr,     aligned);
        chk("wr_data", bus.sys_sw_value, exp_wval);
        if (sys_clk_en) begin
          nwr++;
          wval = bus.sys_sw_value;
        end
      end else begin
        chk("sw_value_idle", bus.sys_sw_value, 32'h0);
      end
      if (bus_rd && k <= L + 1) begin
        chk("rd_addr",  bus.sys_addr,          aligned);
        chk("rd_wr_en", 32'(bus.sys_wr_en),    32'd0);
      end
      chk("busy_ready", 32'(bus.cpu_req_ready), 32'd0);
      if (bus.cpu_rsp_valid) begin
        seen = 1'b1;
        chk("latency",   32'(k),               32'(exp_lat));
        chk("rsp_rdata", bus.cpu_rsp_rdata,    exp_rdata);
        chk("rsp_err",   32'(bus.cpu_rsp_err), 32'(err));
        chk("n_writes",  32'(nwr),             32'(do_wr));
        last_rdata = bus.cpu_rsp_rdata;
        last_err   = bus.cpu_rsp_err;
      end
    end
    if (!seen) chk("rsp_timeout", 32'd0, 32'd1);
    sys_clk_en = 1'b1;
    if (do_wr) mem[idx] = exp_wval;
    if (!err) last_addr = aligned;
    last_wr = wval;
  endtask

  task automatic do_reset_abort();
    @(negedge sys_clk);
    chk("abort_ready", 32'(bus.cpu_req_ready), 32'd1);
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_we    = 1'b1;
    bus.cpu_req_addr  = 32'h10;
    bus.cpu_req_wdata = 32'h000000AA;
    bus.cpu_req_be    = 4'b0001;
    @(negedge sys_clk);
    bus.cpu_req_valid = 1'b0;
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    chk("abort_wr_en", 32'(bus.sys_wr_en),     32'd0);
    chk("abort_rsp",   32'(bus.cpu_rsp_valid), 32'd0);
    chk("abort_ready", 32'(bus.cpu_req_ready), 32'd1);
    chk("abort_addr",  bus.sys_addr,           32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk);
      chk("abort_quiet_wr",  32'(bus.sys_wr_en),     32'd0);
      chk("abort_quiet_rsp", 32'(bus.cpu_rsp_valid), 32'd0);
      chk("abort_quiet_rdy", 32'(bus.cpu_req_ready), 32'd1);
    end
    last_addr = 32'h0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          we;
    logic [3:0]  be;
    int          mode;
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    last_addr = 32'h0;
    last_wr = 32'h0; last_rdata = 32'h0; last_err = 1'b0;
    bus.cpu_req_valid = 1'b0;
    bus.cpu_req_we    = 1'b0;
    bus.cpu_req_addr  = 32'h0;
    bus.cpu_req_wdata = 32'h0;
    bus.cpu_req_be    = 4'h0;
    bus.sfr_rd_dout   = 32'h0;
    sys_rst_n  = 1'b0;
    sys_clk_en = 1'b0;
    repeat (2) @(negedge sys_clk);
    chk("rst_ready",  32'(bus.cpu_req_ready), 32'd1);
    chk("rst_rsp",    32'(bus.cpu_rsp_valid), 32'd0);
    chk("rst_rdata",  bus.cpu_rsp_rdata,      32'h0);
    chk("rst_err",    32'(bus.cpu_rsp_err),   32'd0);
    chk("rst_addr",   bus.sys_addr,           32'h0);
    chk("rst_wr_en",  32'(bus.sys_wr_en),     32'd0);
    chk("rst_sw",     bus.sys_sw_value,       32'h0);
    sys_clk_en = 1'b1;
    sys_rst_n  = 1'b1;

    // Directed scenarios
    do_req(1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 1'b0);
    chk("tp_full_wval", last_wr, 32'hDEADBEEF);
    mem[1] = 32'h12345678;
    do_req(1'b0, 32'h05, 32'h0, 4'h0, 1'b0);
    chk("tp_load_rdata", last_rdata, 32'h12345678);
    mem[3] = 32'h11223344;
    do_req(1'b1, 32'h0C, 32'h0000AB00, 4'b0010, 1'b0);
    chk("tp_rmw_wval", last_wr, 32'h1122AB44);
    do_req(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 1'b1);
    chk("tp_stall_wval", last_wr, 32'hCAFEF00D);
    do_req(1'b1, 32'h24, 32'h55AA0000, 4'b1100, 1'b1);
    do_req(1'b1, 32'h28, 32'hFFFFFFFF, 4'h0, 1'b0);
    do_reset_abort();
    do_req(1'b1, 32'h140, 32'h0BADF00D, 4'hF, 1'b0);
    chk("tp_err_oor", 32'(last_err), 32'(ADDR_CHECK));
    do_req(1'b0, 32'h13C, 32'h0, 4'h0, 1'b0);
    chk("tp_err_inwin", 32'(last_err), 32'd0);
    do_req(1'b0, 32'h0FC, 32'h0, 4'h0, 1'b0);

    // Randomized traffic
    for (int t = 0; t < 200; t++) begin
      mode = $urandom_range(0, 7);
      we   = (mode >= 3);
      if (mode == 3 || mode == 4)  be = 4'hF;
      else if (mode == 7)          be = 4'h0;
      else                         be = 4'($urandom_range(1, 14));
      do_req(we, 32'($urandom_range(0, 511)), $urandom, be, ($urandom_range(0, 7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
